layer_pingpong_ram: RTL and testbench
=====================================

Name: layer_pingpong_ram

Overview:
Double-buffered (ping-pong) layer activation memory with two banks of 2**A_WIDTH words each. A producer layer fills one bank while the consumer layer reads the other. Bank ownership is handed over by explicit done handshakes. Reads are registered with a valid strobe, and misuse is flagged by sticky error bits.

Parameters:
D_WIDTH, 4, data word width in bits.
A_WIDTH, 4, address width; each bank holds 2**A_WIDTH words.
AUTO_DONE, 0, when 1, a write to address 2**A_WIDTH-1 also acts as w_done.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
w_en  input  1  write strobe into the current write bank
w_addr  input  A_WIDTH  write address
data_in  input  D_WIDTH  write data
w_done  input  1  producer finished the current write bank
w_ready  output  1  current write bank is empty and writable
r_en  input  1  read strobe from the current read bank
r_addr  input  A_WIDTH  read address
data_out  output  D_WIDTH  registered read data
r_valid  output  1  data_out holds fresh data this cycle
r_done  input  1  consumer finished the current read bank
r_ready  output  1  current read bank is full and readable
wr_bank  output  1  index of the current write bank
rd_bank  output  1  index of the current read bank
err_wr  output  1  sticky: write or w_done attempted while w_ready=0
err_rd  output  1  sticky: read or r_done attempted while r_ready=0

Behaviour:
- State is wr_sel, rd_sel and full[1:0]. Outputs: wr_bank=wr_sel, rd_bank=rd_sel, w_ready=~full[wr_sel], r_ready=full[rd_sel].
- Reset values (synchronous, rst sampled on the clk edge): wr_sel=0, rd_sel=0, full=2'b00, data_out=0, r_valid=0, err_wr=0, err_rd=0. Memory contents are not cleared.
- rst has priority over every other input in the same cycle.
- Write (w_en & w_ready): mem[wr_sel][w_addr] <= data_in on the edge.
- A write with w_ready=0 is dropped and sets err_wr.
- Write done fires when (w_done | (AUTO_DONE & w_en & w_addr==all-ones)) & w_ready. It sets full[wr_sel]<=1 and toggles wr_sel.
- A write and a done in the same cycle: the write lands in the old bank before the swap.
- w_done with w_ready=0 sets err_wr and changes no other state.
- Read (r_en & r_ready): data_out <= mem[rd_sel][r_addr], and r_valid<=1 on the next cycle. Latency is exactly 1 clock.
- When no valid read occurs, r_valid<=0 and data_out holds its last value.
- r_en with r_ready=0 sets err_rd and does not assert r_valid.
- Read done (r_done & r_ready) clears full[rd_sel] and toggles rd_sel.
- A read and r_done in the same cycle: the read uses the old bank, and r_valid is asserted next cycle.
- r_done with r_ready=0 sets err_rd and is otherwise ignored.
- Write done and read done in the same cycle act on different banks, and both take effect. A write bank is always empty and a read bank always full, so they can never be the same bank while both are active.
- Both banks full: w_ready=0 and the producer stalls. Both banks empty: r_ready=0 and the consumer stalls.
- No read-during-write hazard exists, because the banks are disjoint whenever both ports are legal.
- Error bits clear only on rst.
- Memory is inferable as two simple-dual-port RAMs, or one RAM of 2**(A_WIDTH+1) words addressed {bank, addr}. Registered output only; no asynchronous read path.

Test Plan:
- Reset, then idle: w_ready=1, r_ready=0, wr_bank=0, rd_bank=0, r_valid=0, data_out=0, err_wr=err_rd=0.
- Fill bank 0 with addr i -> data i (i=0..15), then pulse w_done -> wr_bank=1, r_ready=1, w_ready=1. Read addr 5 -> one cycle later data_out=5, r_valid=1 for exactly one cycle.
- Overlap: fill bank 1 with 15-i while reading all of bank 0, then pulse r_done and w_done in the same cycle -> rd_bank=1, wr_bank=0, full=2'b10. Reading addr 0 returns 15.
- Full stall: fill both banks without r_done -> w_ready=0. A further w_en sets err_wr=1 and bank contents are unchanged on readback. An r_en in the same test with r_ready=1 still works.
- Empty stall: after reset, pulse r_en and r_done -> err_rd=1, r_valid stays 0, rd_bank stays 0.
- AUTO_DONE=1: write addresses 0..15 with no w_done -> after the write to 15, wr_bank=1 and r_ready=1. Apply rst mid-fill of the next bank -> all control outputs return to their reset values.

Source files
------------

// File: rtl/layer_pingpong_ram_if.sv
// Bundle of producer/consumer signals for the ping-pong layer memory.
// Latency: none (wiring only).
// Backpressure: w_ready/r_ready tell each side when its bank may be used.
// Ports (signals):
//   producer side: w_en, w_addr, data_in, w_done -> ; <- w_ready, wr_bank, err_wr
//   consumer side: r_en, r_addr, r_done -> ; <- data_out, r_valid, r_ready, rd_bank, err_rd
// Modports: master = the layers driving requests, slave = the memory.
interface layer_pingpong_ram_if #(
    parameter int D_WIDTH = 4,
    parameter int A_WIDTH = 4
);
    logic               w_en;
    logic [A_WIDTH-1:0] w_addr;
    logic [D_WIDTH-1:0] data_in;
    logic               w_done;
    logic               w_ready;
    logic               r_en;
    logic [A_WIDTH-1:0] r_addr;
    logic [D_WIDTH-1:0] data_out;
    logic               r_valid;
    logic               r_done;
    logic               r_ready;
    logic               wr_bank;
    logic               rd_bank;
    logic               err_wr;
    logic               err_rd;

    modport master (
        output w_en, w_addr, data_in, w_done, r_en, r_addr, r_done,
        input  w_ready, data_out, r_valid, r_ready, wr_bank, rd_bank, err_wr, err_rd
    );

    modport slave (
        input  w_en, w_addr, data_in, w_done, r_en, r_addr, r_done,
        output w_ready, data_out, r_valid, r_ready, wr_bank, rd_bank, err_wr, err_rd
    );
endinterface

// File: rtl/layer_pingpong_ram.sv
// Double-buffered layer activation memory: producer fills one bank, consumer reads the other.
// Latency: read data and r_valid appear exactly 1 clock after an accepted r_en.
// Backpressure: w_ready drops when both banks are full, r_ready drops when both are empty;
//               requests made while not ready are dropped and raise sticky err_wr/err_rd.
// Ports: clk, rst (sync, active-high) plus one layer_pingpong_ram_if.slave bundle.
module layer_pingpong_ram #(
    parameter int D_WIDTH   = 4,
    parameter int A_WIDTH   = 4,
    parameter int AUTO_DONE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_pingpong_ram_if.slave     bus
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam bit AUTO  = (AUTO_DONE != 0);

    // Both banks live in one array addressed {bank, addr}.
    logic [D_WIDTH-1:0] mem [0:2*DEPTH-1];

    logic       wr_sel;
    logic       rd_sel;
    logic [1:0] full;
    logic [1:0] full_nxt;

    logic w_ready_i;
    logic r_ready_i;
    logic wr_fire;
    logic wdone_fire;
    logic rd_fire;
    logic rdone_fire;
    logic auto_hit;

    assign w_ready_i = ~full[wr_sel];
    assign r_ready_i = full[rd_sel];

    assign wr_fire    = bus.w_en & w_ready_i;
    assign auto_hit   = AUTO & bus.w_en & (bus.w_addr == {A_WIDTH{1'b1}});
    assign wdone_fire = (bus.w_done | auto_hit) & w_ready_i;
    assign rd_fire    = bus.r_en & r_ready_i;
    assign rdone_fire = bus.r_done & r_ready_i;

    // The write bank is always empty and the read bank always full, so
    // when both dones fire they touch different bits of full.
    always_comb begin
        full_nxt = full;
        if (wdone_fire) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rdone_fire) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            full       <= 2'b00;
            bus.err_wr <= 1'b0;
            bus.err_rd <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wdone_fire) begin
                wr_sel <= ~wr_sel;
            end
            if (rdone_fire) begin
                rd_sel <= ~rd_sel;
            end
            if ((bus.w_en | bus.w_done) & ~w_ready_i) begin
                bus.err_wr <= 1'b1;
            end
            if ((bus.r_en | bus.r_done) & ~r_ready_i) begin
                bus.err_rd <= 1'b1;
            end
        end
    end

    // Write uses the pre-swap wr_sel, so a write coinciding with done lands
    // in the bank being handed over. Contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[{wr_sel, bus.w_addr}] <= bus.data_in;
        end
    end

    // Registered read port; data_out holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
            bus.r_valid  <= 1'b0;
        end else begin
            bus.r_valid <= rd_fire;
            if (rd_fire) begin
                bus.data_out <= mem[{rd_sel, bus.r_addr}];
            end
        end
    end

    assign bus.w_ready = w_ready_i;
    assign bus.r_ready = r_ready_i;
    assign bus.wr_bank = wr_sel;
    assign bus.rd_bank = rd_sel;
endmodule

// File: tb/tb_layer_pingpong_ram.sv
module tb_layer_pingpong_ram;
    logic clk;
    logic rst0;
    logic rst1;
    int   checks;
    int   errors;

    layer_pingpong_ram_if #(.D_WIDTH(4), .A_WIDTH(4)) b0 ();
    layer_pingpong_ram_if #(.D_WIDTH(4), .A_WIDTH(4)) b1 ();

    layer_pingpong_ram #(.D_WIDTH(4), .A_WIDTH(4), .AUTO_DONE(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    layer_pingpong_ram #(.D_WIDTH(4), .A_WIDTH(4), .AUTO_DONE(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboards of expected read data, one per DUT.
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] e0;
    logic [3:0] e1;

    always @(negedge clk) begin
        if (b0.r_valid === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rd0_unexpected: r_valid=1 data_out=%0d, no read pending", b0.data_out);
            end else begin
                e0 = q0.pop_front();
                if (b0.data_out !== e0) begin
                    errors++;
                    $display("FAIL rd0_data: got %0d expected %0d", b0.data_out, e0);
                end
            end
        end
        if (b1.r_valid === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rd1_unexpected: r_valid=1 data_out=%0d, no read pending", b1.data_out);
            end else begin
                e1 = q1.pop_front();
                if (b1.data_out !== e1) begin
                    errors++;
                    $display("FAIL rd1_data: got %0d expected %0d", b1.data_out, e1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        b0.w_en = 0; b0.w_addr = 0; b0.data_in = 0; b0.w_done = 0;
        b0.r_en = 0; b0.r_addr = 0; b0.r_done = 0;
    endtask

    task automatic idle1();
        b1.w_en = 0; b1.w_addr = 0; b1.data_in = 0; b1.w_done = 0;
        b1.r_en = 0; b1.r_addr = 0; b1.r_done = 0;
    endtask

    // ctrl vector order: {w_ready, r_ready, wr_bank, rd_bank, r_valid, err_wr, err_rd}
    task automatic test_reset();
        logic [6:0] got;
        rst0 = 1; rst1 = 1;
        tick(); tick();
        rst0 = 0; rst1 = 0;
        tick();
        got = {b0.w_ready, b0.r_ready, b0.wr_bank, b0.rd_bank, b0.r_valid, b0.err_wr, b0.err_rd};
        checks++;
        if (got !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", got, 7'b1000000);
        end
        checks++;
        if (b0.data_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d expected 0", b0.data_out);
        end
    endtask

    task automatic test_fill_read();
        for (int i = 0; i < 16; i++) begin
            b0.w_en = 1; b0.w_addr = 4'(i); b0.data_in = 4'(i);
            tick();
        end
        b0.w_en = 0; b0.w_done = 1;
        tick();
        b0.w_done = 0;
        checks++;
        if ({b0.wr_bank, b0.r_ready, b0.w_ready} !== 3'b111) begin
            errors++;
            $display("FAIL fill_swap: wr_bank,r_ready,w_ready got %b expected 111",
                     {b0.wr_bank, b0.r_ready, b0.w_ready});
        end
        b0.r_en = 1; b0.r_addr = 4'd5; q0.push_back(4'd5);
        tick();
        b0.r_en = 0;
        checks++;
        if (b0.r_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_latency: r_valid got %b expected 1", b0.r_valid);
        end
        tick();
        checks++;
        if (b0.r_valid !== 1'b0 || b0.data_out !== 4'd5) begin
            errors++;
            $display("FAIL read_hold: r_valid=%b data_out=%0d expected 0 and 5", b0.r_valid, b0.data_out);
        end
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 16; i++) begin
            b0.w_en = 1; b0.w_addr = 4'(i); b0.data_in = 4'(15 - i);
            b0.r_en = 1; b0.r_addr = 4'(i); q0.push_back(4'(i));
            tick();
        end
        b0.w_en = 0; b0.r_en = 0;
        b0.w_done = 1; b0.r_done = 1;
        tick();
        b0.w_done = 0; b0.r_done = 0;
        // full=2'b10 with wr_sel=0, rd_sel=1 -> w_ready=1, r_ready=1
        checks++;
        if ({b0.rd_bank, b0.wr_bank, b0.w_ready, b0.r_ready} !== 4'b1011) begin
            errors++;
            $display("FAIL overlap_swap: rd_bank,wr_bank,w_ready,r_ready got %b expected 1011",
                     {b0.rd_bank, b0.wr_bank, b0.w_ready, b0.r_ready});
        end
        b0.r_en = 1; b0.r_addr = 4'd0; q0.push_back(4'd15);
        tick();
        b0.r_en = 0;
        tick();
    endtask

    task automatic test_full_stall();
        // Fill bank 0 with i^5; the last write coincides with w_done.
        for (int i = 0; i < 16; i++) begin
            b0.w_en = 1; b0.w_addr = 4'(i); b0.data_in = 4'(i ^ 5);
            b0.w_done = (i == 15);
            tick();
        end
        b0.w_en = 0; b0.w_done = 0;
        checks++;
        if ({b0.w_ready, b0.r_ready, b0.wr_bank} !== 3'b011) begin
            errors++;
            $display("FAIL full_stall: w_ready,r_ready,wr_bank got %b expected 011",
                     {b0.w_ready, b0.r_ready, b0.wr_bank});
        end
        // Dropped write into bank 1 (also the read bank) alongside a legal read.
        b0.w_en = 1; b0.w_addr = 4'd3; b0.data_in = 4'd9;
        b0.r_en = 1; b0.r_addr = 4'd3; q0.push_back(4'd12);
        tick();
        b0.w_en = 0;
        b0.r_addr = 4'd3; q0.push_back(4'd12);
        tick();
        b0.r_en = 0;
        checks++;
        if ({b0.err_wr, b0.err_rd} !== 2'b10) begin
            errors++;
            $display("FAIL full_err: err_wr,err_rd got %b expected 10", {b0.err_wr, b0.err_rd});
        end
        b0.r_done = 1;
        tick();
        b0.r_done = 0;
        checks++;
        if ({b0.rd_bank, b0.w_ready, b0.r_ready, b0.err_wr} !== 4'b0111) begin
            errors++;
            $display("FAIL full_release: rd_bank,w_ready,r_ready,err_wr got %b expected 0111",
                     {b0.rd_bank, b0.w_ready, b0.r_ready, b0.err_wr});
        end
        b0.r_en = 1; b0.r_addr = 4'd3;  q0.push_back(4'd6);
        tick();
        b0.r_addr = 4'd15; q0.push_back(4'd10);
        tick();
        b0.r_en = 0;
        tick();
    endtask

    task automatic test_empty_stall();
        rst0 = 1;
        tick();
        rst0 = 0;
        b0.r_en = 1; b0.r_done = 1;
        tick();
        b0.r_en = 0; b0.r_done = 0;
        tick();
        checks++;
        if ({b0.err_rd, b0.r_valid, b0.rd_bank, b0.err_wr, b0.r_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL empty_stall: err_rd,r_valid,rd_bank,err_wr,r_ready got %b expected 10000",
                     {b0.err_rd, b0.r_valid, b0.rd_bank, b0.err_wr, b0.r_ready});
        end
    endtask

    task automatic test_auto_done();
        logic [6:0] got;
        for (int i = 0; i < 16; i++) begin
            b1.w_en = 1; b1.w_addr = 4'(i); b1.data_in = 4'(i + 1);
            tick();
            if (i == 14) begin
                checks++;
                if ({b1.wr_bank, b1.r_ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL auto_early: wr_bank,r_ready got %b expected 00", {b1.wr_bank, b1.r_ready});
                end
            end
        end
        b1.w_en = 0;
        checks++;
        if ({b1.wr_bank, b1.r_ready, b1.w_ready, b1.err_wr} !== 4'b1110) begin
            errors++;
            $display("FAIL auto_swap: wr_bank,r_ready,w_ready,err_wr got %b expected 1110",
                     {b1.wr_bank, b1.r_ready, b1.w_ready, b1.err_wr});
        end
        b1.r_en = 1; b1.r_addr = 4'd15; q1.push_back(4'd0);
        tick();
        b1.r_addr = 4'd7; q1.push_back(4'd8);
        tick();
        b1.r_en = 0;
        for (int i = 0; i < 8; i++) begin
            b1.w_en = 1; b1.w_addr = 4'(i); b1.data_in = 4'(i);
            tick();
        end
        rst1 = 1;
        tick();
        rst1 = 0; b1.w_en = 0;
        got = {b1.w_ready, b1.r_ready, b1.wr_bank, b1.rd_bank, b1.r_valid, b1.err_wr, b1.err_rd};
        checks++;
        if (got !== 7'b1000000 || b1.data_out !== 4'd0) begin
            errors++;
            $display("FAIL auto_reset: ctrl got %b data_out %0d expected 1000000 and 0", got, b1.data_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst0 = 1; rst1 = 1;
        idle0();
        idle1();
        test_reset();
        test_fill_read();
        test_overlap();
        test_full_stall();
        test_empty_stall();
        test_auto_done();
        tick(); tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d and %0d reads never returned, expected 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
